// File: rtl/spi_pwm_ctrl.sv
// spi_pwm_ctrl
// SPI-slave (mode 0, MSB first) controlled single-channel PWM generator.
// A host writes 16-bit period/duty values with three-byte commands
// (command, data high, data low). Each byte may arrive in its own chip-select
// frame. Written values land in shadow registers. The PWM counter adopts them
// only at a period boundary, so the output never glitches mid-period.
module spi_pwm_ctrl #(
   parameter int         CNT_W       = 16,
   parameter logic [7:0] CMD_PERIOD  = 8'h08,
   parameter logic [7:0] CMD_DUTY    = 8'h09,
   parameter int         SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_spi_mosi,
   input  logic i_spi_clk,
   input  logic i_spi_cs,
   output logic o_pwm
);

   // Byte position inside a three-byte command.
   typedef enum logic [1:0] {
      PH_CMD = 2'd0,
      PH_HI  = 2'd1,
      PH_LO  = 2'd2
   } phase_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   // ---------------------------------------------------------------
   // SPI pin synchronisers and edge detection
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic [SYNC_STAGES-1:0] cs_sync_r;
   logic                   sck_prev_r;

   logic sck_s;
   logic mosi_s;
   logic cs_s;
   logic sck_rise_s;

   // ---------------------------------------------------------------
   // Byte assembly
   // ---------------------------------------------------------------
   logic [2:0] bit_cnt_r;
   logic [7:0] shift_r;
   logic       byte_valid_r;

   // ---------------------------------------------------------------
   // Command decoding and shadow registers
   // ---------------------------------------------------------------
   phase_t           phase_r;
   logic [7:0]       cmd_r;
   logic [7:0]       data_hi_r;
   logic [15:0]      data_word_s;
   logic [CNT_W-1:0] period_shadow_r;
   logic [CNT_W-1:0] duty_shadow_r;

   // ---------------------------------------------------------------
   // PWM engine
   // ---------------------------------------------------------------
   logic [CNT_W-1:0] period_active_r;
   logic [CNT_W-1:0] duty_active_r;
   logic [CNT_W-1:0] cnt_r;
   logic             pwm_r;

   // Bring SCK, MOSI and CS into the i_clk domain. Keep the previous synced
   // SCK so that its rising edge can be detected.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sck_sync_r  <= {SYNC_STAGES{1'b0}};
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
         cs_sync_r   <= {SYNC_STAGES{1'b1}};
         sck_prev_r  <= 1'b0;
      end else begin
         sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], i_spi_clk};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], i_spi_mosi};
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], i_spi_cs};
         sck_prev_r  <= sck_s;
      end
   end

   assign sck_s  = sck_sync_r[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
   assign cs_s   = cs_sync_r[SYNC_STAGES-1];

   // An SCK edge counts only while the slave is selected. All three pins see
   // the same synchroniser delay, so their relative timing is preserved.
   assign sck_rise_s = sck_s & ~sck_prev_r & ~cs_s;

   // Shift in MOSI on each qualified SCK rise. The bit counter wraps to 0 on
   // the eighth bit, and byte_valid fires on the next clock while shift_r
   // holds the finished byte. Deselecting discards a partial byte by
   // restarting the bit count. Leftover bits in shift_r are shifted out by
   // the next full byte.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bit_cnt_r    <= 3'd0;
         shift_r      <= 8'h00;
         byte_valid_r <= 1'b0;
      end else begin
         byte_valid_r <= 1'b0;
         if (cs_s) begin
            bit_cnt_r <= 3'd0;
         end else if (sck_rise_s) begin
            shift_r   <= {shift_r[6:0], mosi_s};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
               byte_valid_r <= 1'b1;
            end else begin
               byte_valid_r <= 1'b0;
            end
         end else begin
            bit_cnt_r <= bit_cnt_r;
         end
      end
   end

   assign data_word_s = {data_hi_r, shift_r};

   // Byte-phase FSM. It walks CMD -> HI -> LO on every received byte. The
   // phase ignores chip select, so a command may be split across frames or
   // left pending indefinitely. Unknown commands still consume both data
   // bytes, which keeps the stream aligned.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_r         <= PH_CMD;
         cmd_r           <= 8'h00;
         data_hi_r       <= 8'h00;
         period_shadow_r <= CNT_MAX;
         duty_shadow_r   <= CNT_ZERO;
      end else if (byte_valid_r) begin
         case (phase_r)
            PH_CMD: begin
               cmd_r   <= shift_r;
               phase_r <= PH_HI;
            end
            PH_HI: begin
               data_hi_r <= shift_r;
               phase_r   <= PH_LO;
            end
            PH_LO: begin
               if (cmd_r == CMD_PERIOD) begin
                  period_shadow_r <= CNT_W'(data_word_s);
               end else if (cmd_r == CMD_DUTY) begin
                  duty_shadow_r <= CNT_W'(data_word_s);
               end else begin
                  period_shadow_r <= period_shadow_r;
               end
               phase_r <= PH_CMD;
            end
            default: begin
               phase_r <= PH_CMD;
            end
         endcase
      end else begin
         phase_r <= phase_r;
      end
   end

   // The PWM counter runs 0..period_active inclusive. At the last count it
   // wraps and takes the shadow values, so a shadow write in that same cycle
   // is only picked up at the following boundary. A zero period reloads every
   // cycle. The output is registered from (cnt < duty). This gives a steady 0
   // for zero duty and a steady 1 when duty exceeds the period.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r           <= CNT_ZERO;
         period_active_r <= CNT_MAX;
         duty_active_r   <= CNT_ZERO;
         pwm_r           <= 1'b0;
      end else begin
         if (cnt_r == period_active_r) begin
            cnt_r           <= CNT_ZERO;
            period_active_r <= period_shadow_r;
            duty_active_r   <= duty_shadow_r;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         pwm_r <= (cnt_r < duty_active_r);
      end
   end

   assign o_pwm = pwm_r;

endmodule

// File: tb/tb_spi_pwm_ctrl.sv
// Self-checking bench for spi_pwm_ctrl.
// The reference model keeps the command stream in a byte queue and decodes
// each complete group of three bytes into expected period/duty values. The
// PWM output is then judged by measured period and high time:
// (period+1) clocks per cycle, duty clocks high, or a constant level when
// duty is 0 or larger than the period.
module tb_spi_pwm_ctrl;

   logic i_clk      = 1'b0;
   logic i_rst_n    = 1'b0;
   logic i_spi_mosi = 1'b0;
   logic i_spi_clk  = 1'b0;
   logic i_spi_cs   = 1'b1;
   logic o_pwm;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int   rise_t[$];
   int   fall_t[$];
   logic pwm_prev = 1'b0;

   logic [7:0] m_q[$];
   int m_period = 65535;
   int m_duty   = 0;
   int run_p    = 65535;

   spi_pwm_ctrl #(
      .CNT_W      (16),
      .CMD_PERIOD (8'h08),
      .CMD_DUTY   (8'h09),
      .SYNC_STAGES(2)
   ) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_spi_mosi(i_spi_mosi),
      .i_spi_clk (i_spi_clk),
      .i_spi_cs  (i_spi_cs),
      .o_pwm     (o_pwm)
   );

   // Free-running system clock.
   always #5 i_clk = ~i_clk;

   // Cycle counter, advanced on every rising edge.
   always @(posedge i_clk) cyc <= cyc + 1;

   // Record o_pwm edge times, sampled away from the active edge.
   always @(negedge i_clk) begin
      if (o_pwm === 1'b1 && pwm_prev === 1'b0) rise_t.push_back(cyc);
      if (o_pwm === 1'b0 && pwm_prev === 1'b1) fall_t.push_back(cyc);
      pwm_prev <= o_pwm;
   end

   // Global time limit.
   initial begin
      #3000000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_period = 65535;
      m_duty   = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      m_q.push_back(b);
      if (m_q.size() == 3) begin
         if (m_q[0] == 8'h08)      m_period = {m_q[1], m_q[2]};
         else if (m_q[0] == 8'h09) m_duty   = {m_q[1], m_q[2]};
         m_q.delete();
      end
   endtask

   // One CS frame carrying the first nbits of b, MSB first, SCK low/high = half clocks.
   task automatic spi_bits(input logic [7:0] b, input int nbits, input int half);
      i_spi_cs = 1'b0;
      tick(half);
      for (int i = 0; i < nbits; i++) begin
         i_spi_mosi = b[7-i];
         tick(half);
         i_spi_clk = 1'b1;
         tick(half);
         i_spi_clk = 1'b0;
      end
      tick(half);
      i_spi_cs = 1'b1;
      tick(half);
   endtask

   task automatic send_byte(input logic [7:0] b);
      spi_bits(b, 8, int'($urandom_range(6, 4)));
      model_byte(b);
   endtask

   task automatic send_cmd(input logic [7:0] c, input logic [15:0] d);
      send_byte(c);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
   endtask

   // Compare o_pwm against the model's current period/duty once they must be active.
   task automatic measure(input string tag);
      int p, d, t, hi, w, ones;
      p = m_period;
      d = m_duty;
      rise_t.delete();
      fall_t.delete();
      if (d == 0 || d > p) begin
         tick(run_p + p + 8);
         w    = 2 * (p + 1) + 16;
         ones = 0;
         for (int i = 0; i < w; i++) begin
            tick(1);
            if (o_pwm === 1'b1) ones++;
         end
         check_val({tag, "_const"}, ones, (d == 0) ? 0 : w);
      end else begin
         t = 0;
         while (rise_t.size() < 3 && t < run_p + 5 * (p + 1) + 64) begin
            tick(1);
            t++;
         end
         check_val({tag, "_rises"}, (rise_t.size() >= 3) ? 1 : 0, 1);
         if (rise_t.size() >= 3) begin
            check_val({tag, "_period"}, rise_t[1] - rise_t[0], p + 1);
            check_val({tag, "_period2"}, rise_t[2] - rise_t[1], p + 1);
            hi = -1;
            foreach (fall_t[i]) begin
               if (hi < 0 && fall_t[i] > rise_t[0]) hi = fall_t[i] - rise_t[0];
            end
            check_val({tag, "_high"}, hi, d);
         end
      end
      run_p = p;
   endtask

   initial begin
      int p0, k, t, ones, rp, rd, mode;
      logic [7:0] junk;

      // Reset and idle.
      model_reset();
      tick(5);
      i_rst_n = 1'b1;
      p0 = cyc;
      rise_t.delete();
      fall_t.delete();
      ones = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (o_pwm === 1'b1) ones++;
      end
      check_val("reset_idle_pwm", ones, 0);

      // Program 512/197 during the reset-default 65536-clock period.
      send_cmd(8'h08, 16'h01FF);
      send_cmd(8'h09, 16'h00C5);
      tick(4);
      check_val("pre_boundary_pwm", o_pwm, 0);
      t = 0;
      while (rise_t.size() < 1 && t < 70000) begin
         tick(1);
         t++;
      end
      check_val("first_boundary_seen", rise_t.size(), 1);
      if (rise_t.size() >= 1) check_val("first_boundary_time", rise_t[0] - p0, 65537);
      run_p = 511;
      measure("cfg_512_197");

      // New period must wait for the end of the current period.
      rise_t.delete();
      fall_t.delete();
      t = 0;
      while (rise_t.size() < 1 && t < 2000) begin
         tick(1);
         t++;
      end
      send_cmd(8'h08, 16'h00FF);
      tick(4);
      k = rise_t.size() - 1;
      t = 0;
      while (rise_t.size() < k + 3 && t < 3000) begin
         tick(1);
         t++;
      end
      check_val("reload_rises", (k >= 0 && rise_t.size() >= k + 3) ? 1 : 0, 1);
      if (k >= 0 && rise_t.size() >= k + 3) begin
         check_val("old_period_kept", rise_t[k+1] - rise_t[k], 512);
         check_val("new_period_applied", rise_t[k+2] - rise_t[k+1], 256);
      end
      run_p = 255;

      // Incomplete command stays pending; the final byte completes it.
      send_byte(8'h09);
      send_byte(8'h05);
      tick(4);
      measure("partial_cmd_pending");
      send_byte(8'h10);
      tick(4);
      measure("duty_over_period");

      // A byte cut short by CS is dropped.
      junk = 8'($urandom());
      spi_bits(junk, 5, 5);
      send_cmd(8'h09, 16'h0064);
      tick(4);
      measure("partial_byte_dropped");

      // Unknown command consumes its data without side effects.
      send_cmd(8'hFF, 16'h1234);
      tick(4);
      measure("unknown_cmd");
      send_cmd(8'h09, 16'h0020);
      tick(4);
      measure("after_unknown_cmd");

      // Zero period.
      send_cmd(8'h08, 16'h0000);
      send_cmd(8'h09, 16'h0001);
      tick(4);
      measure("period0_duty1");
      send_cmd(8'h09, 16'h0000);
      tick(4);
      measure("period0_duty0");
      send_cmd(8'h08, 16'h0040);
      send_cmd(8'h09, 16'h0010);
      tick(4);
      measure("exit_period0");

      // Randomized settings.
      for (int n = 0; n < 5; n++) begin
         rp   = int'($urandom_range(300, 8));
         mode = int'($urandom_range(3, 0));
         case (mode)
            1:       rd = 0;
            2:       rd = int'($urandom_range(65535, rp + 1));
            default: rd = int'($urandom_range(rp, 1));
         endcase
         if ($urandom_range(1, 0) == 1) begin
            send_cmd(8'h08, 16'(rp));
            send_cmd(8'h09, 16'(rd));
         end else begin
            send_cmd(8'h09, 16'(rd));
            send_cmd(8'h08, 16'(rp));
         end
         tick(4);
         measure($sformatf("rand%0d", n));
      end

      // Reset in the middle of a transfer with the output high.
      send_cmd(8'h09, 16'hFFFF);
      tick(4);
      measure("full_duty");
      check_val("pre_reset_pwm", o_pwm, 1);
      i_spi_cs = 1'b0;
      tick(5);
      i_spi_mosi = 1'b1;
      i_spi_clk  = 1'b1;
      tick(5);
      i_spi_clk = 1'b0;
      tick(3);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_val("reset_async_pwm", o_pwm, 0);
      model_reset();
      tick(3);
      i_spi_cs = 1'b1;
      i_rst_n  = 1'b1;
      ones = 0;
      for (int i = 0; i < 200; i++) begin
         tick(1);
         if (o_pwm === 1'b1) ones++;
      end
      check_val("post_reset_idle", ones, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_pwm_ctrl.md
Name: spi_pwm_ctrl

Overview:
- SPI-slave-controlled single-channel PWM generator.
- An external SPI master writes 16-bit period and duty registers using 3-byte commands. Each byte is framed by its own chip-select assertion.
- The PWM counter runs on the system clock. New settings are applied glitch-free at the period boundary.
- Sits between a host MCU SPI bus and a motor/LED driver pin.

Parameters:
- CNT_W, 16, width of period/duty registers and PWM counter.
- CMD_PERIOD, 8'h08, command byte selecting the period register.
- CMD_DUTY, 8'h09, command byte selecting the duty register.
- SYNC_STAGES, 2, flip-flop synchroniser depth for SCK, MOSI and CS.

Ports:
- i_clk  in  1  system clock; all logic runs on its rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_spi_mosi  in  1  SPI data from master, asynchronous to i_clk.
- i_spi_clk  in  1  SPI clock from master (mode 0), asynchronous to i_clk.
- i_spi_cs  in  1  SPI chip select, active low.
- o_pwm  out  1  PWM output, registered.

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - bit counter = 0, byte phase = CMD, shift register = 0.
  - period_active = period_shadow = 16'hFFFF; duty_active = duty_shadow = 0.
  - PWM counter = 0; o_pwm = 0.
- Synchronisation: SCK, MOSI and CS each pass through SYNC_STAGES flops. An SCK rising edge is detected as synced SCK going 0->1 while synced CS = 0.
- SPI sampling (mode 0, MSB first):
  - on each detected SCK rising edge, shift synced MOSI into the 8-bit shift register and increment the bit counter.
  - at the 8th bit, raise a one-cycle byte_valid strobe on the following clock with the assembled byte; the bit counter returns to 0.
- CS high (synced): bit counter cleared and the partial byte discarded. Byte phase is NOT cleared, because each byte may arrive in its own CS frame.
- SCK sampling is required to work for SCK high/low times of at least 4 i_clk cycles.
- Byte-phase FSM, advanced on byte_valid:
  - CMD: latch the byte as cmd, go to HI.
  - HI: latch the byte as data[15:8], go to LO.
  - LO: data[7:0] = byte; on cmd==CMD_PERIOD write period_shadow, on cmd==CMD_DUTY write duty_shadow; go to CMD.
  - Any other cmd value: the two data bytes are consumed and discarded, and the FSM still returns to CMD.
  - An incomplete command (e.g. only 2 bytes sent) stays pending indefinitely, and the next byte continues it.
- PWM counter:
  - counts 0..period_active inclusive, giving a period of period_active+1 clocks.
  - at cnt == period_active: cnt -> 0, period_active <= period_shadow, duty_active <= duty_shadow.
- Output: o_pwm registered, o_pwm <= (cnt < duty_active).
  - duty_active = 0 -> constant 0.
  - duty_active > period_active -> constant 1.
- period_active = 0: counter stays 0 and reloads shadows every cycle; o_pwm = (duty_active != 0).
- Simultaneous shadow write and reload in the same cycle: the reload takes the old shadow value; the new value applies at the next boundary.
- Reset mid-transfer or mid-period returns everything to reset values immediately.

Test Plan:
- Reset, then idle 100 clocks -> o_pwm = 0, period_active = 16'hFFFF, no byte_valid.
- Bytes 0x08, 0x7F, 0xFF, then 0x09, 0x00, 0xC5 (one byte per CS frame, SCK 5 clk low / 5 clk high), then run 2 full periods:
  - period_shadow = 0x7FFF, duty_shadow = 0x00C5.
  - after the next boundary, o_pwm high exactly 197 clocks out of every 32768.
- Then bytes 0x08, 0x01, 0xFF:
  - the new period 0x01FF takes effect only at the current period's end.
  - thereafter o_pwm is high 197 of every 512 clocks.
- Then bytes 0x09, 0x05 only, followed by a long idle:
  - duty unchanged (197/512) and FSM phase = LO.
  - a subsequent byte 0x10 sets duty = 0x0510 > period, so o_pwm becomes constant 1 after the boundary.
- CS raised after 5 bits of a byte, then a full 8-bit byte 0x09 -> the partial byte is ignored and 0x09 is taken as the next byte in sequence.
- Command 0xFF with data 0x12, 0x34 -> no register changes; the next 3-byte command is decoded normally.
